// File: rtl/sram_spi_responder_pkg.sv
// Shared defines for the SPI-attached SRAM responder and memory_controller.
// Holds the serial protocol opcodes and field lengths; no ports.
package sram_spi_responder_pkg;

    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam int         CMD_LEN     = 8;
    localparam int         ADDRESS_LEN = 24;
    localparam int         WORD_SIZE   = 16;
    localparam int         BIT_CNT_W   = 5;

endpackage

// File: rtl/sram_spi_responder_word_array.sv
// sram_word_array: word storage for the SPI SRAM responder.
// One synchronous write port and one asynchronous read port.
// Contents are not reset.
//   clk   : clock, write on posedge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module sram_word_array #(
    parameter int ADDR_BITS = 5,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sram_spi_responder.sv
// SPI-style serial SRAM responder. A transaction is framed by cs low:
// 8-bit command (MSB first), 24-bit address (MSB first, only the low
// ADDR_BITS kept), then a burst of data words shifted LSB first.
// Reads and writes auto-increment the word address with wrap-around.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset (qualified by ena)
//   ena   : clock enable; when low everything holds and so reads 0
//   cs    : chip select, active low
//   si    : serial data in
//   so    : serial data out (registered, 0 outside READ)
//   busy  : registered, high while a transaction is in progress
//
// state    | meaning
// S_IDLE   | waiting for cs low; first sampled bit is command bit 7
// S_CMD    | shifting remaining command bits
// S_ADDR   | shifting 24 address bits
// S_WRITE  | shifting write data, one word per WORD_SIZE bits
// S_READ   | driving read data on so, LSB first, sequential burst
// S_IGNORE | unknown command; waiting for cs high
module sram_spi_responder #(
    parameter int ADDR_BITS = 5,
    parameter int WORD_SIZE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic cs,
    input  logic si,
    output logic so,
    output logic busy
);

    import sram_spi_responder_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_IGNORE
    } state_t;

    localparam logic [BIT_CNT_W-1:0] CMD_LAST  = BIT_CNT_W'(CMD_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(ADDRESS_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] WORD_LAST = BIT_CNT_W'(WORD_SIZE - 1);

    state_t               state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [ADDR_BITS-1:0] addr, addr_nxt;
    logic [6:0]           cmd_sr, cmd_sr_nxt;
    logic [WORD_SIZE-2:0] wr_sr, wr_sr_nxt;
    logic                 op_read, op_read_nxt;
    logic                 so_q, so_nxt;
    logic                 busy_q, busy_nxt;
    // Cleared by reset; a transaction may only start after cs has been
    // seen high, so a reset inside a frame cannot resume mid-frame.
    logic                 armed, armed_nxt;

    logic [7:0]           cmd_full;
    logic [ADDR_BITS-1:0] addr_shift;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [WORD_SIZE-1:0] rd_data;
    logic [WORD_SIZE-1:0] wr_word;
    logic                 mem_we;

    assign cmd_full   = {cmd_sr, si};
    assign addr_shift = {addr[ADDR_BITS-2:0], si};
    assign addr_inc   = addr + ADDR_BITS'(1);
    assign wr_word    = {si, wr_sr};

    // Read address looks ahead: the word being loaded into so on this edge
    // is the freshly completed address, or the next word at a burst boundary.
    always_comb begin
        rd_addr = addr;
        if (state == S_ADDR) begin
            rd_addr = addr_shift;
        end else if (state == S_READ && bit_cnt == WORD_LAST) begin
            rd_addr = addr_inc;
        end
    end

    sram_word_array #(
        .ADDR_BITS (ADDR_BITS),
        .WORD_SIZE (WORD_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we && ena && rst_n),
        .waddr (addr),
        .wdata (wr_word),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        addr_nxt    = addr;
        cmd_sr_nxt  = cmd_sr;
        wr_sr_nxt   = wr_sr;
        op_read_nxt = op_read;
        armed_nxt   = armed;
        so_nxt      = 1'b0;
        mem_we      = 1'b0;

        if (cs) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            armed_nxt   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (armed) begin
                        cmd_sr_nxt  = {6'b0, si};
                        bit_cnt_nxt = BIT_CNT_W'(1);
                        state_nxt   = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_sr_nxt = cmd_full[6:0];
                    if (bit_cnt == CMD_LAST) begin
                        bit_cnt_nxt = '0;
                        if (cmd_full == OP_READ) begin
                            op_read_nxt = 1'b1;
                            state_nxt   = S_ADDR;
                        end else if (cmd_full == OP_WRITE) begin
                            op_read_nxt = 1'b0;
                            state_nxt   = S_ADDR;
                        end else begin
                            state_nxt   = S_IGNORE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end
                end
                S_ADDR: begin
                    addr_nxt = addr_shift;
                    if (bit_cnt == ADDR_LAST) begin
                        bit_cnt_nxt = '0;
                        if (op_read) begin
                            so_nxt    = rd_data[0];
                            state_nxt = S_READ;
                        end else begin
                            state_nxt = S_WRITE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    wr_sr_nxt = wr_word[WORD_SIZE-1:1];
                    if (bit_cnt == WORD_LAST) begin
                        mem_we      = 1'b1;
                        addr_nxt    = addr_inc;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (bit_cnt == WORD_LAST) begin
                        addr_nxt    = addr_inc;
                        so_nxt      = rd_data[0];
                        bit_cnt_nxt = '0;
                    end else begin
                        so_nxt      = |(rd_data & (WORD_SIZE'(1) << (bit_cnt + BIT_CNT_W'(1))));
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end
                end
                S_IGNORE: begin
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                addr    <= '0;
                cmd_sr  <= '0;
                wr_sr   <= '0;
                op_read <= 1'b0;
                so_q    <= 1'b0;
                busy_q  <= 1'b0;
                armed   <= 1'b0;
            end else begin
                state   <= state_nxt;
                bit_cnt <= bit_cnt_nxt;
                addr    <= addr_nxt;
                cmd_sr  <= cmd_sr_nxt;
                wr_sr   <= wr_sr_nxt;
                op_read <= op_read_nxt;
                so_q    <= so_nxt;
                busy_q  <= busy_nxt;
                armed   <= armed_nxt;
            end
        end
    end

    assign so   = so_q && ena;
    assign busy = busy_q;

endmodule
